// File: rtl/iir_mac_filter.sv
// ---------------------------------------------------------------------------
// iir_mac_filter
//
// Direct-form-I IIR filter with independent feed-forward (X_TAPS) and
// feedback (Y_TAPS) orders, built around one multiplier per path that is
// time-multiplexed over the taps. It pops samples from a show-ahead FIFO,
// keeps every input in the x history, and after DECIMATION inputs computes
//   y[n] = sum_k (X_COEFF[k]*x[n-k] >>> FRAC_BITS)
//        + sum_{k>=1} (Y_COEFF[k]*y[n-k] >>> FRAC_BITS)
// over max(X_TAPS,Y_TAPS) MAC cycles. The result is then pushed into the
// downstream FIFO.
//
// Optional feature (compile-time macro IIR_MAC_SATURATE_EN):
//   defined   - the accumulator is clamped to the DATA_WIDTH signed range
//   undefined - the low DATA_WIDTH accumulator bits are used (wrap-around)
//
// Ports:
//   clock      single clock
//   reset      synchronous, active-high; has priority over every input
//   in_dout    input FIFO head, valid while in_empty = 0
//   in_empty   input FIFO empty
//   in_rd_en   pop the input FIFO this cycle
//   out_din    output sample (0 whenever out_wr_en = 0)
//   out_wr_en  push out_din this cycle
//   out_full   output FIFO full
// ---------------------------------------------------------------------------
module iir_mac_filter #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  parameter int X_TAPS     = 2,
  parameter int Y_TAPS     = 2,
  parameter logic [0:X_TAPS-1][DATA_WIDTH-1:0] X_COEFF =
    {DATA_WIDTH'(178), DATA_WIDTH'(178)},
  parameter logic [0:Y_TAPS-1][DATA_WIDTH-1:0] Y_COEFF =
    {DATA_WIDTH'(0), DATA_WIDTH'(-666)},
  parameter int DECIMATION = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  out_wr_en,
  input  logic                  out_full
);

  localparam int ACC_WIDTH  = DATA_WIDTH + 8;
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int M_TAPS     = (X_TAPS > Y_TAPS) ? X_TAPS : Y_TAPS;
  localparam int TAP_W      = (M_TAPS > 1) ? $clog2(M_TAPS) : 1;
  localparam int DEC_W      = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

  typedef enum logic [1:0] {
    ST_READ,
    ST_MAC,
    ST_WRITE
  } state_t;

  state_t state, state_next;

  logic [DEC_W-1:0]             dec_cnt;
  logic [TAP_W-1:0]             tap_idx;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [DATA_WIDTH-1:0] x_hist [X_TAPS];
  logic signed [DATA_WIDTH-1:0] y_hist [Y_TAPS];

  logic dec_last;
  logic tap_last;

  assign dec_last = (dec_cnt == DEC_W'(DECIMATION - 1));
  assign tap_last = (tap_idx == TAP_W'(M_TAPS - 1));

  // -------------------------------------------------------------------------
  // Tap selection. Indices beyond a path's order select a zero coefficient,
  // so that path contributes nothing. The feedback path starts at t = 1 and
  // reads y_hist[t-1], which holds y[n-t] while y[n] is being computed.
  // -------------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] x_coef, x_samp, y_coef, y_samp;
  logic signed [PROD_WIDTH-1:0] x_prod, y_prod;
  logic signed [ACC_WIDTH-1:0]  x_term, y_term;

  // NOTE: every variable gets a default before the loops; without it the
  // "no tap matches" path would hold the old value and infer a latch.
  always_comb begin
    x_coef = '0;
    x_samp = '0;
    y_coef = '0;
    y_samp = '0;
    for (int k = 0; k < X_TAPS; k++) begin
      if (tap_idx == TAP_W'(k)) begin
        x_coef = X_COEFF[k];
        x_samp = x_hist[k];
      end
    end
    for (int k = 1; k < Y_TAPS; k++) begin
      if (tap_idx == TAP_W'(k)) begin
        y_coef = Y_COEFF[k];
        y_samp = y_hist[k-1];
      end
    end
  end

  // Full-width signed products, arithmetic shift, then truncation to the
  // accumulator width.
  assign x_prod = PROD_WIDTH'(x_coef) * PROD_WIDTH'(x_samp);
  assign y_prod = PROD_WIDTH'(y_coef) * PROD_WIDTH'(y_samp);
  assign x_term = ACC_WIDTH'(x_prod >>> FRAC_BITS);
  assign y_term = ACC_WIDTH'(y_prod >>> FRAC_BITS);

  // -------------------------------------------------------------------------
  // Accumulator reduction to the output width.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] result;

`ifdef IIR_MAC_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH-DATA_WIDTH:0] acc_hi;
  logic                          acc_fits;

  // The value fits when every bit from the output sign bit upward agrees.
  assign acc_hi   = acc[ACC_WIDTH-1:DATA_WIDTH-1];
  assign acc_fits = (&acc_hi) | ~(|acc_hi);
  assign result   = acc_fits ? acc[DATA_WIDTH-1:0]
                             : (acc[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX);
`else
  assign result = DATA_WIDTH'(acc);
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_READ;
    else       state <= state_next;
  end

  // -------------------------------------------------------------------------
  // FSM: next state and FIFO handshakes. Reset forces both strobes low so a
  // sample is never popped or pushed in a cycle whose effects are discarded.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    out_din    = '0;
    if (!reset) begin
      unique case (state)
        ST_READ: begin
          if (!in_empty) begin
            in_rd_en = 1'b1;
            if (dec_last) state_next = ST_MAC;
          end
        end
        ST_MAC: begin
          if (tap_last) state_next = ST_WRITE;
        end
        ST_WRITE: begin
          if (!out_full) begin
            out_wr_en  = 1'b1;
            out_din    = result;
            state_next = ST_READ;
          end
        end
        default: state_next = ST_READ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: histories, decimation counter, tap index, accumulator.
  // -------------------------------------------------------------------------
  // NOTE: the history arrays are reset explicitly because a restarted filter
  // must compute its next output from zeroed history, not stale samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      dec_cnt <= '0;
      tap_idx <= '0;
      acc     <= '0;
      for (int k = 0; k < X_TAPS; k++) x_hist[k] <= '0;
      for (int k = 0; k < Y_TAPS; k++) y_hist[k] <= '0;
    end else begin
      unique case (state)
        ST_READ: begin
          if (!in_empty) begin
            // Every popped sample enters the x history; only the last of a
            // decimation group starts a computation.
            x_hist[0] <= in_dout;
            for (int k = 1; k < X_TAPS; k++) x_hist[k] <= x_hist[k-1];
            if (dec_last) begin
              dec_cnt <= '0;
              tap_idx <= '0;
              acc     <= '0;
            end else begin
              dec_cnt <= dec_cnt + DEC_W'(1);
            end
          end
        end
        ST_MAC: begin
          acc     <= acc + x_term + y_term;
          tap_idx <= tap_last ? '0 : tap_idx + TAP_W'(1);
        end
        ST_WRITE: begin
          // While the output FIFO is full nothing moves.
          if (!out_full) begin
            y_hist[0] <= result;
            for (int k = 1; k < Y_TAPS; k++) y_hist[k] <= y_hist[k-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_mac_filter.sv
// ---------------------------------------------------------------------------
// tb_iir_mac_filter
//
// Directed bench for iir_mac_filter. Four instances cover the parameter sets
// of interest:
//   u_def : default parameters (impulse, backpressure, reset mid-MAC)
//   u_dc  : X_COEFF={512,512}, Y_TAPS=1 (DC step and latency)
//   u_dec : DECIMATION=2, X_TAPS=1, X_COEFF={1024}, Y_TAPS=1
//   u_ovf : X_TAPS=1, X_COEFF={2048}, Y_TAPS=1 (overflow / saturation)
// Expected outputs are queued when a stimulus is driven and popped by a
// monitor whenever any instance pushes a sample. Only one instance is fed at
// a time, so a single queue suffices.
// ---------------------------------------------------------------------------
module tb_iir_mac_filter;

  localparam int N_DUT = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [N_DUT-1:0][31:0] din;
  logic [N_DUT-1:0]       empty;
  logic [N_DUT-1:0]       full;
  wire  [N_DUT-1:0]       rd;
  wire  [N_DUT-1:0]       wr;
  wire  [N_DUT-1:0][31:0] dout;

  always #5 clock = ~clock;

  iir_mac_filter u_def (
    .clock(clock), .reset(reset),
    .in_dout(din[0]), .in_empty(empty[0]), .in_rd_en(rd[0]),
    .out_din(dout[0]), .out_wr_en(wr[0]), .out_full(full[0])
  );

  iir_mac_filter #(
    .X_COEFF({32'sd512, 32'sd512}),
    .Y_TAPS (1),
    .Y_COEFF({32'sd0})
  ) u_dc (
    .clock(clock), .reset(reset),
    .in_dout(din[1]), .in_empty(empty[1]), .in_rd_en(rd[1]),
    .out_din(dout[1]), .out_wr_en(wr[1]), .out_full(full[1])
  );

  iir_mac_filter #(
    .X_TAPS    (1),
    .X_COEFF   ({32'sd1024}),
    .Y_TAPS    (1),
    .Y_COEFF   ({32'sd0}),
    .DECIMATION(2)
  ) u_dec (
    .clock(clock), .reset(reset),
    .in_dout(din[2]), .in_empty(empty[2]), .in_rd_en(rd[2]),
    .out_din(dout[2]), .out_wr_en(wr[2]), .out_full(full[2])
  );

  iir_mac_filter #(
    .X_TAPS (1),
    .X_COEFF({32'sd2048}),
    .Y_TAPS (1),
    .Y_COEFF({32'sd0})
  ) u_ovf (
    .clock(clock), .reset(reset),
    .in_dout(din[3]), .in_empty(empty[3]), .in_rd_en(rd[3]),
    .out_din(dout[3]), .out_wr_en(wr[3]), .out_full(full[3])
  );

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int          n_vec  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          pop_cyc = 0;
  int          rd_cnt   [N_DUT] = '{0, 0, 0, 0};
  int          wr_cnt   [N_DUT] = '{0, 0, 0, 0};
  int          first_wr [N_DUT] = '{-1, -1, -1, -1};
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  always @(posedge clock) cyc++;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    for (int d = 0; d < N_DUT; d++) begin
      if (rd[d]) rd_cnt[d]++;
      if (wr[d]) begin
        wr_cnt[d]++;
        if (first_wr[d] < 0) first_wr[d] = cyc;
        check($sformatf("rd_wr_exclusive_%0d", d), 32'(rd[d]), 32'd0);
        check($sformatf("write_expected_%0d", d), 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0)
          check($sformatf("out_din_%0d", d), dout[d], exp_q.pop_front());
      end
    end
  end

  // Present one sample on a show-ahead FIFO head and wait for it to be popped.
  task automatic feed(input int d, input logic [31:0] v);
    bit seen = 1'b0;
    din[d]   = v;
    empty[d] = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (rd[d]) seen = 1'b1;
    end
    if (seen) begin
      pop_cyc = cyc;
      @(posedge clock);
      #1;
    end
    empty[d] = 1'b1;
    din[d]   = '0;
    check($sformatf("popped_%0d", d), 32'(seen), 32'd1);
  endtask

  // Wait, with a cycle budget, until every queued expectation was consumed.
  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    int w0;
    int r0;

    reset = 1'b1;
    din   = '0;
    empty = '1;
    full  = '0;
    repeat (3) @(posedge clock);
    #1;

    // Reset wins over a non-empty input FIFO.
    din[0]   = 32'd123;
    empty[0] = 1'b0;
    @(negedge clock);
    check("reset_rd_en",   32'(rd[0]), 32'd0);
    check("reset_wr_en",   32'(wr[0]), 32'd0);
    check("reset_out_din", dout[0],    32'd0);
    empty[0] = 1'b1;
    din[0]   = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Impulse response with default coefficients.
    exp_q.push_back(32'sd178);
    exp_q.push_back(32'sd62);
    exp_q.push_back(-32'sd41);
    feed(0, 32'sd1024);
    feed(0, 32'sd0);
    feed(0, 32'sd0);
    drain();

    // DC step and first-output latency (M = 2 -> 3 cycles).
    for (int i = 0; i < 4; i++) exp_q.push_back(i == 0 ? 32'sd500 : 32'sd1000);
    feed(1, 32'sd1000);
    r0 = pop_cyc;
    for (int i = 0; i < 3; i++) feed(1, 32'sd1000);
    drain();
    check("dc_latency", 32'(first_wr[1] - r0), 32'd3);

    // Decimation by two: four pops, two writes carrying the later samples.
    r0 = rd_cnt[2];
    w0 = wr_cnt[2];
    exp_q.push_back(32'sd6);
    exp_q.push_back(32'sd8);
    feed(2, 32'sd5);
    feed(2, 32'sd6);
    feed(2, 32'sd7);
    feed(2, 32'sd8);
    drain();
    check("dec_rd_pulses", 32'(rd_cnt[2] - r0), 32'd4);
    check("dec_wr_pulses", 32'(wr_cnt[2] - w0), 32'd2);

    // Overflow at both ends of the range.
`ifdef IIR_MAC_SATURATE_EN
    exp_q.push_back(32'h7FFF_FFFF);
    feed(3, 32'h7FFF_FFFF);
    exp_q.push_back(32'h8000_0000);
    feed(3, 32'h8000_0000);
`else
    exp_q.push_back(32'hFFFF_FFFE);
    feed(3, 32'h7FFF_FFFF);
    exp_q.push_back(32'h0000_0000);
    feed(3, 32'h8000_0000);
`endif
    drain();

    // Backpressure: output FIFO full for 10 cycles in WRITE while another
    // input sample is already waiting.
    pulse_reset();
    w0 = wr_cnt[0];
    full[0] = 1'b1;
    exp_q.push_back(32'sd178);
    feed(0, 32'sd1024);
    din[0]   = 32'sd1024;
    empty[0] = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("stall_wr_en",   32'(wr[0]), 32'd0);
      check("stall_rd_en",   32'(rd[0]), 32'd0);
      check("stall_out_din", dout[0],    32'd0);
    end
    @(posedge clock);
    #1;
    // x = {1024,1024}, y[n-1] = 178: 178 + 178 + (-118548 >>> 10 = -116).
    exp_q.push_back(32'sd240);
    full[0] = 1'b0;
    feed(0, 32'sd1024);
    drain();
    check("stall_write_count", 32'(wr_cnt[0] - w0), 32'd2);

    // Reset during the second MAC cycle discards the result and all history.
    w0 = wr_cnt[0];
    feed(0, 32'sd1024);
    @(posedge clock);
    #1;
    pulse_reset();
    repeat (6) @(posedge clock);
    #1;
    check("reset_mid_mac_no_write", 32'(wr_cnt[0] - w0), 32'd0);
    exp_q.push_back(32'sd0);
    feed(0, 32'sd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iir_mac_filter.md
Name: iir_mac_filter

Overview:
- Parametrised direct-form-I IIR filter for the FM demod chain: de-emphasis, audio low-pass and similar stages.
- Generalises the fixed 2-tap de-emphasis stage to independent feed-forward and feedback orders, a configurable fixed-point format, decimation and optional output saturation.
- Sits between two FIFOs: it reads through a show-ahead FIFO interface and writes into the next stage's FIFO.
- Uses one shared multiply-accumulate pair time-multiplexed over the taps.

Parameters:
- DATA_WIDTH, 32, sample and coefficient width, signed two's complement.
- FRAC_BITS, 10, fractional bits of the coefficients; each product is arithmetically shifted right by this amount.
- X_TAPS, 2, feed-forward taps (>=1).
- Y_TAPS, 2, feedback taps (>=1); Y_COEFF[0] is ignored.
- X_COEFF, {178,178}, packed [0:X_TAPS-1][DATA_WIDTH-1:0]; index k multiplies x[n-k].
- Y_COEFF, {0,-666}, packed [0:Y_TAPS-1][DATA_WIDTH-1:0]; index k multiplies y[n-k].
- DECIMATION, 1, input samples consumed per output sample (>=1).

Ports:
- clock  in  1  Single clock.
- reset  in  1  Synchronous, active-high.
- in_dout  in  DATA_WIDTH  Input FIFO head, valid when in_empty=0.
- in_empty  in  1  Input FIFO empty.
- in_rd_en  out  1  Pop input FIFO this cycle.
- out_din  out  DATA_WIDTH  Output sample.
- out_wr_en  out  1  Push out_din this cycle.
- out_full  in  1  Output FIFO full.

Behaviour:
- Equation: y[n] = sum_{k=0..X_TAPS-1} (X_COEFF[k]*x[n-k] >>> FRAC_BITS) + sum_{k=1..Y_TAPS-1} (Y_COEFF[k]*y[n-k] >>> FRAC_BITS).
- Arithmetic:
  - Products are full 2*DATA_WIDTH signed.
  - Each shifted product is truncated to ACC_WIDTH = DATA_WIDTH+8 and summed into one ACC_WIDTH accumulator.
  - The result is reduced to DATA_WIDTH (see Optional Feature).
- History:
  - x_hist[0:X_TAPS-1] and y_hist[0:Y_TAPS-1] are shift registers, index 0 newest.
  - Both are all zero after reset.
- State READ:
  - When in_empty=0: assert in_rd_en for one cycle and shift in_dout into x_hist.
  - Increment the decimation counter; on count DECIMATION-1, wrap it to 0, clear the accumulator and go to MAC.
  - When in_empty=1: stay in READ, in_rd_en=0.
  - All DECIMATION inputs enter x_hist; only the last one triggers a computation.
- State MAC:
  - One cycle per index t = 0..max(X_TAPS,Y_TAPS)-1.
  - Each cycle adds the x term for t<X_TAPS and the y term for 1<=t<Y_TAPS, using y_hist[t-1] as y[n-t].
  - On the last index go to WRITE with the accumulator final.
  - Never asserts in_rd_en or out_wr_en.
- State WRITE:
  - If out_full=0: out_wr_en=1, out_din = y[n] (the newly computed sample), shift y[n] into y_hist, go to READ.
  - If out_full=1: hold, out_wr_en=0; the accumulator and histories are frozen.
- Latency: in the READ cycle that pops the triggering sample, out_wr_en asserts M+1 cycles later, where M = max(X_TAPS,Y_TAPS), provided out_full=0.
- Throughput: one output per DECIMATION+M+1 cycles, unstalled.
- Outputs: out_din=0 whenever out_wr_en=0; in_rd_en and out_wr_en are never both 1.
- Reset values: in_rd_en=0, out_wr_en=0, out_din=0, state READ, decimation counter 0, accumulator 0.
- Reset mid-MAC or mid-WRITE: the partial result is discarded and nothing is written; the next output is computed from zeroed history.
- Reset has priority over all other inputs in the same cycle.

Optional Feature:
- Macro: IIR_MAC_SATURATE_EN.
- Defined: the final accumulator value is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] before output. The clamped value is both written and stored in y_hist.
- Undefined: the low DATA_WIDTH bits of the accumulator are taken (wrap-around).

Test Plan:
- Impulse, default parameters: input 1024,0,0 -> outputs 178, 62, -41 (y1 = 178 + (-118548>>>10 = -116); y2 = -41292>>>10 = -41).
- DC step, X_COEFF={512,512}, Y_TAPS=1: input 1000 x4 -> outputs 500,1000,1000,1000; first out_wr_en exactly 3 cycles after the first in_rd_en (M=2).
- Decimation, DECIMATION=2, X_TAPS=1, X_COEFF={1024}, Y_TAPS=1: input 5,6,7,8 -> outputs 6,8; four in_rd_en pulses, two out_wr_en pulses.
- Backpressure: hold out_full=1 for 10 cycles in WRITE -> out_wr_en stays 0, in_rd_en stays 0 and out_din=0 throughout; on release a single write of the correct value.
- Overflow, X_TAPS=1, X_COEFF={2048}, Y_TAPS=1, input 0x7FFFFFFF -> output 0xFFFFFFFE without IIR_MAC_SATURATE_EN, 0x7FFFFFFF with it.
- Reset in the second MAC cycle after input 1024 -> no write occurs; then input 0 -> output 0, confirming both histories were cleared.
